// File: rtl/cn_minsum_serial_if.sv
// Handshake bundle for the serial min-sum check node: variable-to-check input
// stream and check-to-variable output stream.
interface cn_minsum_serial_if #(
    parameter int W     = 16,
    parameter int IDX_W = 3
);
    logic [W-1:0]     vr_msg_in;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     cn_msg_out;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output vr_msg_in, in_valid, out_ready,
        input  in_ready, cn_msg_out, out_idx, out_last, out_valid
    );

    modport slave (
        input  vr_msg_in, in_valid, out_ready,
        output in_ready, cn_msg_out, out_idx, out_last, out_valid
    );
endinterface

// File: rtl/cn_minsum_serial.sv
// Serial offset min-sum check-node processor: collects DEG messages, tracks the
// two smallest magnitudes and the sign product, then streams DEG replies back.
module cn_minsum_serial #(
    parameter int INT    = 8,
    parameter int FRAC   = 8,
    parameter int DEG    = 6,
    parameter int OFFSET = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    cn_minsum_serial_if.slave  bus
);
    localparam int W     = INT + FRAC;
    localparam int M     = W - 1;
    localparam int IDX_W = $clog2(DEG);

    localparam logic [M-1:0]     MAG_MAX  = {M{1'b1}};
    localparam logic [M-1:0]     OFS      = M'(OFFSET);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] in_cnt_reg;
    logic [M-1:0]     min1_reg, min2_reg;
    logic [IDX_W-1:0] min1_idx_reg;
    logic             sign_acc_reg;
    logic [DEG-1:0]   sign_store_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [W-1:0]     out_msg_reg;
    logic [IDX_W-1:0] out_idx_reg;
    logic             out_last_reg;

    logic [W-1:0]     msg_neg;
    logic [M-1:0]     mag;
    logic [M-1:0]     min1_next, min2_next;
    logic [IDX_W-1:0] min1_idx_next;
    logic             sign_acc_next;
    logic [DEG-1:0]   sign_store_next;
    logic [IDX_W-1:0] out_idx_next;

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.cn_msg_out = out_msg_reg;
    assign bus.out_idx    = out_idx_reg;
    assign bus.out_last   = out_last_reg;

    // Magnitude of the incoming message; the most negative code saturates.
    always_comb begin
        msg_neg = ~bus.vr_msg_in + W'(1);
        if (bus.vr_msg_in[W-1] && (bus.vr_msg_in[M-1:0] == '0))
            mag = MAG_MAX;
        else if (bus.vr_msg_in[W-1])
            mag = msg_neg[M-1:0];
        else
            mag = bus.vr_msg_in[M-1:0];
    end

    // Strict less-than keeps the earliest index as min1 on a tie.
    always_comb begin
        min1_next     = min1_reg;
        min2_next     = min2_reg;
        min1_idx_next = min1_idx_reg;
        if (mag < min1_reg) begin
            min2_next     = min1_reg;
            min1_next     = mag;
            min1_idx_next = in_cnt_reg;
        end else if (mag < min2_reg) begin
            min2_next = mag;
        end
    end

    assign sign_acc_next = sign_acc_reg ^ bus.vr_msg_in[W-1];
    assign out_idx_next  = out_idx_reg + IDX_W'(1);

    generate
        for (genvar gi = 0; gi < DEG; gi++) begin : g_sign
            assign sign_store_next[gi] = (in_cnt_reg == IDX_W'(gi)) ? bus.vr_msg_in[W-1]
                                                                    : sign_store_reg[gi];
        end
    endgenerate

    function automatic logic [W-1:0] form_msg(
        input logic [IDX_W-1:0] j,
        input logic [M-1:0]     m1,
        input logic [M-1:0]     m2,
        input logic [IDX_W-1:0] m1_idx,
        input logic             s_acc,
        input logic [DEG-1:0]   s_store
    );
        logic [M-1:0] m;
        logic [W-1:0] v;
        m = (j == m1_idx) ? m2 : m1;
        m = (m > OFS) ? (m - OFS) : '0;
        v = {1'b0, m};
        if ((s_acc ^ s_store[j]) && (m != '0))
            v = ~v + W'(1);
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= COLLECT;
            in_cnt_reg     <= '0;
            min1_reg       <= MAG_MAX;
            min2_reg       <= MAG_MAX;
            min1_idx_reg   <= '0;
            sign_acc_reg   <= 1'b0;
            sign_store_reg <= '0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_msg_reg    <= '0;
            out_idx_reg    <= '0;
            out_last_reg   <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (bus.in_valid) begin
                        min1_reg       <= min1_next;
                        min2_reg       <= min2_next;
                        min1_idx_reg   <= min1_idx_next;
                        sign_acc_reg   <= sign_acc_next;
                        sign_store_reg <= sign_store_next;
                        if (in_cnt_reg == LAST_IDX) begin
                            // First reply is formed from the just-updated statistics.
                            state_reg     <= EMIT;
                            in_cnt_reg    <= '0;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            out_idx_reg   <= '0;
                            out_last_reg  <= 1'b0;
                            out_msg_reg   <= form_msg('0, min1_next, min2_next, min1_idx_next,
                                                      sign_acc_next, sign_store_next);
                        end else begin
                            in_cnt_reg <= in_cnt_reg + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_reg) begin
                            state_reg      <= COLLECT;
                            min1_reg       <= MAG_MAX;
                            min2_reg       <= MAG_MAX;
                            min1_idx_reg   <= '0;
                            sign_acc_reg   <= 1'b0;
                            sign_store_reg <= '0;
                            in_ready_reg   <= 1'b1;
                            out_valid_reg  <= 1'b0;
                            out_msg_reg    <= '0;
                            out_idx_reg    <= '0;
                            out_last_reg   <= 1'b0;
                        end else begin
                            out_idx_reg  <= out_idx_next;
                            out_last_reg <= (out_idx_next == LAST_IDX);
                            out_msg_reg  <= form_msg(out_idx_next, min1_reg, min2_reg, min1_idx_reg,
                                                     sign_acc_reg, sign_store_reg);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cn_minsum_serial.sv
// Directed bench for cn_minsum_serial: a plain build and an OFFSET=0x40 build
// run in lockstep on the same stimulus.
module tb_cn_minsum_serial;
    localparam int W     = 16;
    localparam int DEG   = 6;
    localparam int IDX_W = 3;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [W-1:0] msg       = '0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] frm     [DEG];
    logic [W-1:0] exp_out [DEG];

    logic [W-1:0]     o_msg;
    logic [IDX_W-1:0] o_idx;
    logic             o_last, o_valid, o_ready;

    always #5 clk = ~clk;

    cn_minsum_serial_if #(.W(W), .IDX_W(IDX_W)) bus0 ();
    cn_minsum_serial_if #(.W(W), .IDX_W(IDX_W)) bus1 ();

    assign bus0.vr_msg_in = msg;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.vr_msg_in = msg;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    cn_minsum_serial #(.INT(8), .FRAC(8), .DEG(DEG), .OFFSET(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    cn_minsum_serial #(.INT(8), .FRAC(8), .DEG(DEG), .OFFSET(64)) dut_ofs (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    task automatic sample(input bit sel);
        o_msg   = sel ? bus1.cn_msg_out : bus0.cn_msg_out;
        o_idx   = sel ? bus1.out_idx    : bus0.out_idx;
        o_last  = sel ? bus1.out_last   : bus0.out_last;
        o_valid = sel ? bus1.out_valid  : bus0.out_valid;
        o_ready = sel ? bus1.in_ready   : bus0.in_ready;
    endtask

    // Feeds frm[] one message per cycle; returns #1 after the last accept edge.
    task automatic send_frame(input string tag);
        for (int k = 0; k < DEG; k++) begin
            int n;
            n = 0;
            while (!bus0.in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (bus0.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready before input %0d: got %b want 1", tag, k, bus0.in_ready);
            end
            msg      = frm[k];
            in_valid = 1'b1;
            @(posedge clk); #1;
            $display("%s in  k=%0d msg=%h", tag, k, frm[k]);
        end
        in_valid = 1'b0;
        msg      = '0;
    endtask

    // Drains a frame comparing against exp_out[], optionally stalling at one index.
    task automatic recv_frame(input bit sel, input int stall_idx, input int stall_cycles,
                              input string tag);
        for (int j = 0; j < DEG; j++) begin
            if (j == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(posedge clk); #1;
                    sample(sel);
                    checks++;
                    if (o_valid !== 1'b1 || o_idx !== IDX_W'(j) || o_msg !== exp_out[j]) begin
                        errors++;
                        $display("FAIL %s hold idx %0d: got v=%b idx=%0d msg=%h want v=1 idx=%0d msg=%h",
                                 tag, j, o_valid, o_idx, o_msg, j, exp_out[j]);
                    end
                end
                out_ready = 1'b1;
            end
            sample(sel);
            checks++;
            if (o_valid !== 1'b1 || o_idx !== IDX_W'(j) || o_msg !== exp_out[j] ||
                o_last !== (j == DEG - 1)) begin
                errors++;
                $display("FAIL %s out %0d: got v=%b idx=%0d last=%b msg=%h want v=1 idx=%0d last=%b msg=%h",
                         tag, j, o_valid, o_idx, o_last, o_msg, j, (j == DEG - 1), exp_out[j]);
            end
            $display("%s out idx=%0d msg=%h last=%b", tag, o_idx, o_msg, o_last);
            @(posedge clk); #1;
        end
        sample(sel);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s return to collect: got in_ready=%b out_valid=%b want 1 0",
                     tag, o_ready, o_valid);
        end
    endtask

    task automatic load_nominal();
        frm     = '{16'h0300, 16'hFE80, 16'h0200, 16'hFC00, 16'h0080, 16'h0600};
        exp_out = '{16'h0080, 16'hFF80, 16'h0080, 16'hFF80, 16'h0180, 16'h0080};
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.cn_msg_out !== 16'h0000 ||
            bus0.out_idx !== 3'd0 || bus0.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset values: got rdy=%b v=%b msg=%h idx=%0d last=%b want 1 0 0000 0 0",
                     bus0.in_ready, bus0.out_valid, bus0.cn_msg_out, bus0.out_idx, bus0.out_last);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        load_nominal();
        send_frame("nominal");
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL nominal latency: got out_valid=%b in_ready=%b want 1 0",
                     bus0.out_valid, bus0.in_ready);
        end
        recv_frame(1'b0, -1, 0, "nominal");
    endtask

    task automatic test_backpressure();
        load_nominal();
        send_frame("bp");
        recv_frame(1'b0, 2, 3, "bp");
    endtask

    task automatic test_saturation();
        frm     = '{16'h8000, 16'h0100, 16'h0100, 16'h0400, 16'h0500, 16'h0600};
        exp_out = '{16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        send_frame("sat");
        recv_frame(1'b0, -1, 0, "sat");
    endtask

    task automatic test_offset();
        load_nominal();
        exp_out = '{16'h0040, 16'hFFC0, 16'h0040, 16'hFFC0, 16'h0140, 16'h0040};
        send_frame("ofs");
        recv_frame(1'b1, -1, 0, "ofs");
        frm     = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
        exp_out = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        send_frame("ofs_floor");
        recv_frame(1'b1, -1, 0, "ofs_floor");
    endtask

    task automatic test_reset_mid();
        load_nominal();
        for (int k = 0; k < 3; k++) begin
            msg      = frm[k];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset in collect: got in_ready=%b out_valid=%b want 1 0",
                     bus0.in_ready, bus0.out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_frame("rst_emit");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.out_idx !== 3'd3 || bus0.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset pre-emit idx: got idx=%0d v=%b want 3 1", bus0.out_idx, bus0.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.out_idx !== 3'd0 ||
            bus0.cn_msg_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset in emit: got rdy=%b v=%b idx=%0d msg=%h want 1 0 0 0000",
                     bus0.in_ready, bus0.out_valid, bus0.out_idx, bus0.cn_msg_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_frame("rst_fresh");
        recv_frame(1'b0, -1, 0, "rst_fresh");
    endtask

    task automatic test_back_to_back();
        load_nominal();
        send_frame("b2b_a");
        recv_frame(1'b0, -1, 0, "b2b_a");
        frm     = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        exp_out = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        send_frame("b2b_b");
        recv_frame(1'b0, -1, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_saturation();
        test_offset();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
